// File: rtl/requant_array.sv
`default_nettype none
// ============================================================================
//  Module      : requant_array
//  Description : Multi-lane int requantiser. Each lane computes
//                sat(round(acc*m0 / 2^FIXED_SHIFT) + zp), with optional ReLU.
//                It has a 3-stage valid/ready pipeline and a per-lane scale table.
//  Revision    : 1.0  initial release
// ============================================================================
module requant_array #(
    parameter int LANES       = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int M0_WIDTH    = 32,
    parameter int FIXED_SHIFT = 16,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(LANES)-1:0]     cfg_lane_i,
    input  logic [M0_WIDTH-1:0]          cfg_m0_i,
    input  logic [OUT_WIDTH-1:0]         cfg_zp_i,
    input  logic                         cfg_relu_i,
    input  logic                         cfg_commit_i,
    output logic                         cfg_loaded_o,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [LANES*ACC_WIDTH-1:0]   in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [LANES*OUT_WIDTH-1:0]   out_data_o
);

    // One guard bit over the full product so the rounding add can never wrap.
    localparam int c_rw = ACC_WIDTH + M0_WIDTH + 1;
    localparam int c_vw = c_rw + 1;

    localparam logic signed [c_rw-1:0] c_half = c_rw'(1) << (FIXED_SHIFT - 1);
    localparam logic signed [c_vw-1:0] c_sat_hi =
        {{(c_vw-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_vw-1:0] c_sat_lo =
        {{(c_vw-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic r_loaded;
    logic r_relu;
    logic r_s1_valid;
    logic r_s2_valid;
    logic r_s3_valid;
    logic r_s1_relu;
    logic r_s2_relu;

    logic w_s1_adv;
    logic w_s2_adv;
    logic w_s3_adv;
    logic w_accept;

    // Each stage advances when its successor is empty or advancing itself.
    assign w_s3_adv   = ~r_s3_valid | out_ready_i;
    assign w_s2_adv   = ~r_s2_valid | w_s3_adv;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign in_ready_o = r_loaded & ~cfg_we_i & w_s1_adv;
    assign w_accept   = in_valid_i & in_ready_o;

    assign cfg_loaded_o = r_loaded;
    assign out_valid_o  = r_s3_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_loaded   <= 1'b0;
            r_relu     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s1_relu  <= 1'b0;
            r_s2_relu  <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                r_relu <= cfg_relu_i;
            end
            if (cfg_commit_i) begin
                r_loaded <= 1'b1;
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_relu <= r_relu;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_s2_relu <= r_s1_relu;
            end
            if (w_s3_adv) begin
                r_s3_valid <= r_s2_valid;
            end
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic signed [M0_WIDTH-1:0]  r_m0;
            logic signed [OUT_WIDTH-1:0] r_zp;
            logic signed [ACC_WIDTH-1:0] r_s1_acc;
            logic signed [M0_WIDTH-1:0]  r_s1_m0;
            logic signed [OUT_WIDTH-1:0] r_s1_zp;
            logic signed [c_rw-1:0]      r_s2_r;
            logic signed [OUT_WIDTH-1:0] r_s2_zp;
            logic        [OUT_WIDTH-1:0] r_s3_data;

            logic signed [c_rw-1:0]      w_prod;
            logic signed [c_rw-1:0]      w_round;
            logic signed [c_vw-1:0]      w_sum;
            logic signed [c_vw-1:0]      w_zp_ext;
            logic signed [c_vw-1:0]      w_clip;
            logic        [OUT_WIDTH-1:0] w_sat;

            assign w_prod   = c_rw'(r_s1_acc) * c_rw'(r_s1_m0);
            assign w_round  = (w_prod + c_half) >>> FIXED_SHIFT;
            assign w_zp_ext = c_vw'(r_s2_zp);
            assign w_sum    = c_vw'(r_s2_r) + w_zp_ext;
            assign w_clip   = (r_s2_relu && (w_sum < w_zp_ext)) ? w_zp_ext : w_sum;

            always_comb begin
                w_sat = w_clip[OUT_WIDTH-1:0];
                if (w_clip > c_sat_hi) begin
                    w_sat = c_sat_hi[OUT_WIDTH-1:0];
                end else if (w_clip < c_sat_lo) begin
                    w_sat = c_sat_lo[OUT_WIDTH-1:0];
                end
            end

            // Lane indices with no matching lane simply match no g_lane entry.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_m0      <= '0;
                    r_zp      <= '0;
                    r_s1_acc  <= '0;
                    r_s1_m0   <= '0;
                    r_s1_zp   <= '0;
                    r_s2_r    <= '0;
                    r_s2_zp   <= '0;
                    r_s3_data <= '0;
                end else begin
                    if (cfg_we_i && (int'(cfg_lane_i) == k)) begin
                        r_m0 <= cfg_m0_i;
                        r_zp <= cfg_zp_i;
                    end
                    if (w_accept) begin
                        r_s1_acc <= in_data_i[k*ACC_WIDTH +: ACC_WIDTH];
                        r_s1_m0  <= r_m0;
                        r_s1_zp  <= r_zp;
                    end
                    if (w_s2_adv && r_s1_valid) begin
                        r_s2_r  <= w_round;
                        r_s2_zp <= r_s1_zp;
                    end
                    if (w_s3_adv && r_s2_valid) begin
                        r_s3_data <= w_sat;
                    end
                end
            end

            assign out_data_o[k*OUT_WIDTH +: OUT_WIDTH] = r_s3_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_requant_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_requant_array
//  Description : Directed and randomized bench for requant_array against an
//                arithmetic reference model with a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_requant_array;

    localparam int LANES = 8;
    localparam int AW    = 32;
    localparam int MW    = 32;
    localparam int FS    = 16;
    localparam int OW    = 8;
    localparam int IW    = LANES * AW;
    localparam int VW    = LANES * OW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_we_i = 1'b0;
    logic [2:0]    cfg_lane_i = '0;
    logic [MW-1:0] cfg_m0_i = '0;
    logic [OW-1:0] cfg_zp_i = '0;
    logic          cfg_relu_i = 1'b0;
    logic          cfg_commit_i = 1'b0;
    logic          cfg_loaded_o;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [IW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [VW-1:0] out_data_o;

    requant_array #(
        .LANES(LANES), .ACC_WIDTH(AW), .M0_WIDTH(MW), .FIXED_SHIFT(FS), .OUT_WIDTH(OW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_we_i(cfg_we_i), .cfg_lane_i(cfg_lane_i), .cfg_m0_i(cfg_m0_i),
        .cfg_zp_i(cfg_zp_i), .cfg_relu_i(cfg_relu_i), .cfg_commit_i(cfg_commit_i),
        .cfg_loaded_o(cfg_loaded_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    longint       m_m0 [LANES];
    longint       m_zp [LANES];
    bit           m_relu = 1'b0;
    logic [VW-1:0] exp_q [$];
    int            cyc_q [$];
    logic [VW-1:0] out_log [$];
    bit            lat_exact = 1'b0;
    bit            last_acc = 1'b0;
    bit            stall_prev = 1'b0;
    logic [VW-1:0] stall_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // round-half-up of acc*m0/2^FS via floor division, then zero point, ReLU, clamp
    function automatic logic [OW-1:0] ref_lane(input longint acc, input longint m0,
                                               input longint zp, input bit relu);
        longint num, d, r, v;
        num = acc * m0 + (64'sd1 <<< (FS - 1));
        d   = 64'sd1 <<< FS;
        r   = num / d;
        if (num < 0 && (num % d) != 0) r = r - 1;
        v = r + zp;
        if (relu && v < zp) v = zp;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[OW-1:0];
    endfunction

    function automatic logic [VW-1:0] ref_vec(input logic [IW-1:0] d);
        logic [VW-1:0] v;
        logic [AW-1:0] a;
        for (int k = 0; k < LANES; k++) begin
            a = d[k*AW +: AW];
            v[k*OW +: OW] = ref_lane(longint'($signed(a)), m_m0[k], m_zp[k], m_relu);
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_acc();
        if ($urandom_range(0, 3) == 0) return $urandom();
        return AW'(int'($urandom_range(0, 4000)) - 2000);
    endfunction

    function automatic logic [IW-1:0] rand_vec();
        logic [IW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*AW +: AW] = rand_acc();
        return v;
    endfunction

    // One clock cycle: observe handshakes before the edge, update model, advance.
    task automatic tick();
        logic          acc_hs, out_hs;
        logic [VW-1:0] e;
        int            ca;
        #1;
        acc_hs = in_valid_i & in_ready_o & ~rst_i;
        out_hs = out_valid_o & out_ready_i & ~rst_i;
        if (stall_prev && !rst_i) begin
            chk("stall_valid", 64'(out_valid_o), 64'd1);
            chk("stall_data", out_data_o, stall_data);
        end
        if (out_hs) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid_o), 64'd0);
            end else begin
                e  = exp_q.pop_front();
                ca = cyc_q.pop_front();
                chk("out_data", out_data_o, e);
                if (lat_exact) chk("latency", 64'(cyc - ca), 64'd3);
                out_log.push_back(out_data_o);
            end
        end
        stall_prev = out_valid_o & ~out_ready_i & ~rst_i;
        stall_data = out_data_o;
        last_acc   = acc_hs;
        if (acc_hs) begin
            exp_q.push_back(ref_vec(in_data_i));
            cyc_q.push_back(cyc);
        end
        if (rst_i) begin
            for (int k = 0; k < LANES; k++) begin
                m_m0[k] = 0;
                m_zp[k] = 0;
            end
            m_relu = 1'b0;
            exp_q.delete();
            cyc_q.delete();
        end else if (cfg_we_i) begin
            m_m0[cfg_lane_i] = longint'($signed(cfg_m0_i));
            m_zp[cfg_lane_i] = longint'($signed(cfg_zp_i));
            m_relu = cfg_relu_i;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic cfg_write(input int lane, input logic [MW-1:0] m0,
                             input logic [OW-1:0] zp, input bit relu);
        cfg_we_i   = 1'b1;
        cfg_lane_i = 3'(lane);
        cfg_m0_i   = m0;
        cfg_zp_i   = zp;
        cfg_relu_i = relu;
        #1;
        chk("ready_in_cfg_write", 64'(in_ready_o), 64'd0);
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] d);
        int n = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 100);
        if (!last_acc) chk("send_timeout", 64'(last_acc), 64'd1);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] d;
        int            sent;
        int            base;
        logic [VW-1:0] a_out, b_out;

        for (int k = 0; k < LANES; k++) begin
            m_m0[k] = 0;
            m_zp[k] = 0;
        end

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_data", out_data_o, 64'd0);
        chk("rst_loaded", 64'(cfg_loaded_o), 64'd0);
        rst_i = 1'b0;
        out_ready_i = 1'b1;

        // Nothing accepted before commit
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data_i = rand_vec();
            tick();
            chk("precommit_ready", 64'(in_ready_o), 64'd0);
            chk("precommit_out_valid", 64'(out_valid_o), 64'd0);
        end
        in_valid_i = 1'b0;

        // Rounding
        for (int k = 0; k < LANES; k++) cfg_write(k, 32'h8000, 8'd0, 1'b0);
        chk("loaded_before_commit", 64'(cfg_loaded_o), 64'd0);
        cfg_commit_i = 1'b1;
        tick();
        cfg_commit_i = 1'b0;
        chk("loaded_after_commit", 64'(cfg_loaded_o), 64'd1);
        lat_exact = 1'b1;
        d = rand_vec();
        d[0*AW +: AW] = 32'd100;
        d[1*AW +: AW] = 32'd3;
        d[2*AW +: AW] = -32'sd3;
        send(d);
        drain();
        a_out = out_log[$];
        chk("round_100", 64'(a_out[0*OW +: OW]), 64'd50);
        chk("round_3", 64'(a_out[1*OW +: OW]), 64'd2);
        chk("round_m3", 64'(a_out[2*OW +: OW]), 64'hFF);

        // Saturation and zero point
        cfg_write(0, 32'h10000, 8'd0, 1'b0);
        cfg_write(1, 32'h10000, 8'd0, 1'b0);
        cfg_write(2, 32'h10000, 8'd5, 1'b0);
        cfg_write(3, 32'h10000, 8'd5, 1'b0);
        d = rand_vec();
        d[0*AW +: AW] = 32'd1000;
        d[1*AW +: AW] = -32'sd1000;
        d[2*AW +: AW] = 32'd10;
        d[3*AW +: AW] = 32'd125;
        send(d);
        drain();
        a_out = out_log[$];
        chk("sat_pos", 64'(a_out[0*OW +: OW]), 64'h7F);
        chk("sat_neg", 64'(a_out[1*OW +: OW]), 64'h80);
        chk("zp_add", 64'(a_out[2*OW +: OW]), 64'd15);
        chk("zp_sat", 64'(a_out[3*OW +: OW]), 64'h7F);

        // ReLU with negative zero point
        cfg_write(0, 32'h10000, 8'hF6, 1'b1);
        cfg_write(1, 32'h10000, 8'hF6, 1'b1);
        d = rand_vec();
        d[0*AW +: AW] = -32'sd50;
        d[1*AW +: AW] = 32'd20;
        send(d);
        drain();
        a_out = out_log[$];
        chk("relu_clamp", 64'(a_out[0*OW +: OW]), 64'hF6);
        chk("relu_pass", 64'(a_out[1*OW +: OW]), 64'd10);

        // Backpressure: 20 random beats, downstream stalled 5 cycles mid-stream
        lat_exact = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            cfg_write(k, ($urandom_range(0, 3) == 0) ? $urandom()
                         : MW'(int'($urandom_range(0, 262144)) - 131072),
                      OW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        base = out_log.size();
        sent = 0;
        for (int c = 0; sent < 20 && c < 200; c++) begin
            in_valid_i  = 1'b1;
            in_data_i   = rand_vec();
            out_ready_i = !(c >= 6 && c < 11);
            tick();
            if (last_acc) sent++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain();
        chk("bp_count", 64'(out_log.size() - base), 64'd20);

        // Random valid/ready traffic
        base = out_log.size();
        sent = 0;
        for (int c = 0; sent < 60 && c < 2000; c++) begin
            if (!in_valid_i || last_acc) begin
                in_valid_i = ($urandom_range(0, 9) < 7);
                in_data_i  = rand_vec();
            end
            out_ready_i = ($urandom_range(0, 9) < 7);
            tick();
            if (last_acc) sent++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain();
        chk("rand_count", 64'(out_log.size() - base), 64'(sent));

        // Config hazard: beat A before, beat B after a lane-2 write
        lat_exact = 1'b1;
        for (int k = 0; k < LANES; k++) cfg_write(k, 32'h10000, 8'd0, 1'b0);
        d = rand_vec();
        d[2*AW +: AW] = 32'd50;
        send(d);
        cfg_write(2, 32'h20000, 8'd0, 1'b0);
        send(d);
        drain();
        a_out = out_log[out_log.size() - 2];
        b_out = out_log[out_log.size() - 1];
        chk("hazard_old_m0", 64'(a_out[2*OW +: OW]), 64'd50);
        chk("hazard_new_m0", 64'(b_out[2*OW +: OW]), 64'd100);

        // Reset mid-stream with the output stalled
        lat_exact   = 1'b0;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data_i = rand_vec();
            tick();
        end
        chk("prereset_valid", 64'(out_valid_o), 64'd1);
        rst_i = 1'b1;
        tick();
        chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_loaded", 64'(cfg_loaded_o), 64'd0);
        chk("midrst_out_data", out_data_o, 64'd0);
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_ready", 64'(in_ready_o), 64'd0);
            chk("postrst_out_valid", 64'(out_valid_o), 64'd0);
        end
        in_valid_i = 1'b0;

        // Reload only lane 0; the other lanes must come from a cleared table
        cfg_write(0, 32'h10000, 8'd3, 1'b0);
        cfg_commit_i = 1'b1;
        tick();
        cfg_commit_i = 1'b0;
        lat_exact = 1'b1;
        d = rand_vec();
        d[0*AW +: AW] = 32'd40;
        d[1*AW +: AW] = 32'd500;
        send(d);
        drain();
        a_out = out_log[$];
        chk("reload_lane0", 64'(a_out[0*OW +: OW]), 64'd43);
        chk("cleared_lane1", 64'(a_out[1*OW +: OW]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
